// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - MIPS fetch stage: sequential PC generation, imem req/ack, {pc,inst} FIFO to decode (optional FETCH_STATS_EN)
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [31:0]                id_inst,
    output logic [31:0]                id_pc,
    output logic [$clog2(DEPTH+1)-1:0] q_count
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]                stat_flush_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t          state, state_nxt;
    logic [31:0]     fpc, fpc_nxt, addr_nxt, fpc_inc;
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count_nxt;
    logic            push, pop;

    // A response is only queued from REQ; a redirect in the same cycle wins and drops it
    assign push     = (state == REQ) & imem_ack & ~redirect;
    assign pop      = id_valid & id_ready;
    assign fpc_inc  = fpc + 32'd4;
    assign imem_req = (state == REQ) | (state == DROP);
    assign id_valid = (q_count != '0);
    assign id_pc    = id_valid ? pc_mem[rd_ptr]   : 32'h0;
    assign id_inst  = id_valid ? inst_mem[rd_ptr] : 32'h0;

    // Occupancy after this cycle's push/pop, ignoring flush
    always_comb begin
        count_nxt = q_count;
        if (push && !pop) begin
            count_nxt = q_count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = q_count - CW'(1);
        end
    end

    // Fetch FSM: next state, next fetch PC and held request address
    always_comb begin
        state_nxt = state;
        fpc_nxt   = fpc;
        addr_nxt  = imem_addr;
        if (redirect) begin
            fpc_nxt = redirect_pc & 32'hFFFF_FFFC;
            case (state)
                REQ, DROP: state_nxt = imem_ack ? IDLE : DROP;
                default:   state_nxt = IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (q_count < CW'(DEPTH)) begin
                        state_nxt = REQ;
                        addr_nxt  = fpc;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        fpc_nxt   = fpc_inc;
                        addr_nxt  = fpc_inc;
                        state_nxt = (count_nxt < CW'(DEPTH)) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    // Flush emptied the queue, so the redirected fetch always has room
                    if (imem_ack) begin
                        state_nxt = REQ;
                        addr_nxt  = fpc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, PC and FIFO control registers; redirect flushes the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            imem_addr <= RESET_PC;
            q_count   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            fpc       <= fpc_nxt;
            imem_addr <= addr_nxt;
            if (redirect) begin
                q_count <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end else begin
                q_count <= count_nxt;
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // FIFO storage write; entries are qualified by q_count so no reset needed
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr]   <= fpc;
            inst_mem[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_STATS_EN
    logic        discard;
    logic [1:0]  stat_inc;
    logic [16:0] stat_sum;

    assign discard  = imem_req & imem_ack & ((state == DROP) | redirect);
    assign stat_inc = {1'b0, redirect} + {1'b0, discard};
    assign stat_sum = {1'b0, stat_flush_cnt} + {15'b0, stat_inc};

    // Saturating count of redirect cycles plus discarded responses
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_flush_cnt <= 16'h0;
        end else begin
            stat_flush_cnt <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue (vectors + scoreboard)
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_ack, redirect, id_ready, id_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, id_inst, id_pc;
    logic [2:0]  q_count;
`ifdef FETCH_STATS_EN
    logic [15:0] stat_flush_cnt;
    logic [15:0] stat0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic       ack;
        logic       rdy;
        logic       e_req;
        logic       e_valid;
        logic [2:0] e_cnt;
    } vec_t;

    ent_t        sb[$];
    ent_t        e_pop;
    logic [31:0] exp_addr = 32'h0;
    bit          drop_pending = 1'b0;
    vec_t        vt[12];

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .q_count     (q_count)
`ifdef FETCH_STATS_EN
        ,
        .stat_flush_cnt (stat_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Scoreboard: pops compared at decode, expected entries pushed on each accepted ack
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_addr     = 32'h0;
            drop_pending = 1'b0;
        end else begin
            if (id_valid && id_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: popped pc %h with nothing expected", id_pc);
                end else begin
                    e_pop = sb.pop_front();
                    chk("pop_pc", id_pc, e_pop.pc);
                    chk("pop_inst", id_inst, e_pop.inst);
                end
            end
            if (imem_req && imem_ack) begin
                if (drop_pending || redirect) begin
                    drop_pending = 1'b0;
                end else begin
                    chk("ack_addr", imem_addr, exp_addr);
                    sb.push_back('{pc: exp_addr, inst: mem_word(exp_addr)});
                    exp_addr = exp_addr + 32'd4;
                end
            end
            if (redirect) begin
                sb.delete();
                exp_addr     = redirect_pc & 32'hFFFF_FFFC;
                drop_pending = imem_req && !imem_ack;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ack, rdy -> req, valid, count after the edge
        vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd2};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd3};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd4};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd4};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd3};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd2};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd2};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd1};
        vt[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
        vt[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1};

        // Reset values
        do_reset();
        chk("rst_req",   32'(imem_req), 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_count", 32'(q_count), 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_pc",    id_pc, 32'h0);
        chk("rst_inst",  id_inst, 32'h0);

        // Zero-wait memory, decode always ready: one instruction per cycle
        imem_ack = 1'b1; id_ready = 1'b1;
        step();
        chk("t1_valid_c1", 32'(id_valid), 32'h0);
        step();
        chk("t1_valid_c2", 32'(id_valid), 32'h1);
        chk("t1_pc_c2", id_pc, 32'h0);
        for (int i = 0; i < 14; i++) begin
            step();
            chk("t1_count", 32'(q_count), 32'h1);
        end

        // Fill with decode stalled, then drain and resume at 0x10
        do_reset();
        for (int i = 0; i < 12; i++) begin
            imem_ack = vt[i].ack;
            id_ready = vt[i].rdy;
            step();
            chk($sformatf("vec%0d_req", i),   32'(imem_req), 32'(vt[i].e_req));
            chk($sformatf("vec%0d_valid", i), 32'(id_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d_count", i), 32'(q_count),  32'(vt[i].e_cnt));
        end

        // Slow memory: address held while waiting for ack
        do_reset();
        step();
        for (int r = 0; r < 2; r++) begin
            imem_ack = 1'b0;
            for (int k = 0; k < 4; k++) begin
                chk("t3_addr",  imem_addr, 32'(r * 4));
                chk("t3_req",   32'(imem_req), 32'h1);
                chk("t3_count", 32'(q_count), 32'(r));
                if (k < 3) step();
            end
            imem_ack = 1'b1;
            step();
        end
        imem_ack = 1'b0;
        chk("t3_count_end", 32'(q_count), 32'h2);

        // Redirect with an unacked request outstanding -> DROP
        do_reset();
        imem_ack = 1'b1;
        step(); step(); step();
        imem_ack = 1'b0;
        step();
`ifdef FETCH_STATS_EN
        stat0 = stat_flush_cnt;
`endif
        redirect = 1'b1; redirect_pc = 32'h105;
        step();
        redirect = 1'b0;
        chk("t4_count", 32'(q_count), 32'h0);
        chk("t4_valid", 32'(id_valid), 32'h0);
        chk("t4_req",   32'(imem_req), 32'h1);
        chk("t4_addr_held", imem_addr, 32'h8);
        imem_ack = 1'b1;
        step();
        chk("t4_addr_new", imem_addr, 32'h104);
        chk("t4_count_drop", 32'(q_count), 32'h0);
        step();
        chk("t4_count_push", 32'(q_count), 32'h1);
`ifdef FETCH_STATS_EN
        chk("t4_stat", 32'(stat_flush_cnt), 32'(stat0 + 16'd2));
`endif
        imem_ack = 1'b0; id_ready = 1'b1;
        step();
        chk("t4_drained", 32'(q_count), 32'h0);

        // Redirect with same-cycle ack and a pop, queue at 3
        do_reset();
        imem_ack = 1'b1;
        step(); step(); step(); step();
        chk("t5_pre_count", 32'(q_count), 32'h3);
`ifdef FETCH_STATS_EN
        stat0 = stat_flush_cnt;
`endif
        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0; id_ready = 1'b0; imem_ack = 1'b0;
        chk("t5_count", 32'(q_count), 32'h0);
        chk("t5_valid", 32'(id_valid), 32'h0);
        chk("t5_req_idle", 32'(imem_req), 32'h0);
`ifdef FETCH_STATS_EN
        chk("t5_stat", 32'(stat_flush_cnt), 32'(stat0 + 16'd2));
`endif
        step();
        chk("t5_req", 32'(imem_req), 32'h1);
        chk("t5_addr", imem_addr, 32'h200);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0; id_ready = 1'b1;
        step();

        // Reset pulse mid-request; ack during reset is ignored
        do_reset();
        step();
        chk("t6_req_pre", 32'(imem_req), 32'h1);
        rst = 1'b1; imem_ack = 1'b1;
        step();
        rst = 1'b0; imem_ack = 1'b0;
        chk("t6_req",   32'(imem_req), 32'h0);
        chk("t6_addr",  imem_addr, 32'h0);
        chk("t6_count", 32'(q_count), 32'h0);
        chk("t6_valid", 32'(id_valid), 32'h0);
        chk("t6_pc",    id_pc, 32'h0);
        step();
        chk("t6_restart_req",  32'(imem_req), 32'h1);
        chk("t6_restart_addr", imem_addr, 32'h0);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0; id_ready = 1'b1;
        step();
        chk("t6_drained", 32'(q_count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
